axi4_lite_command_master: RTL and testbench

- Single-outstanding AXI4-Lite master; sits directly upstream of the team's AXI4-Lite slave and drives its AW/W/B/AR/R channels.
- Converts a simple valid/ready command port (one read or one write per command) into a full AXI4-Lite transaction.
- Returns the read data and response on a valid/ready response port.
- Used by test harnesses and control logic to access slave register banks.

---
 rtl/axi4_lite_command_master_if.sv | 57 +++++
 rtl/axi4_lite_command_master.sv | 139 +++++++++++++
 tb/tb_axi4_lite_command_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_command_master_if.sv
// rtl/axi4_lite_command_master_if.sv - AXI4-Lite AW/W/B/AR/R bundle between command master and slave
interface axi4_lite_command_master_if #(
   parameter int p_ADDRESS_WIDTH = 2,
   parameter int p_DATA_WIDTH    = 8
);
   localparam int lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? p_DATA_WIDTH / 8 : 1;

   logic [p_ADDRESS_WIDTH-1:0] awaddr;
   logic [2:0]                 awprot;
   logic                       awvalid;
   logic                       awready;

   logic [p_DATA_WIDTH-1:0]    wdata;
   logic [lp_STROBE_WIDTH-1:0] wstrb;
   logic                       wvalid;
   logic                       wready;

   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;

   logic [p_ADDRESS_WIDTH-1:0] araddr;
   logic [2:0]                 arprot;
   logic                       arvalid;
   logic                       arready;

   logic [p_DATA_WIDTH-1:0]    rdata;
   logic [1:0]                 rresp;
   logic                       rvalid;
   logic                       rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_lite_command_master.sv
// rtl/axi4_lite_command_master.sv - single-outstanding AXI4-Lite master fed by a command/response port
module axi4_lite_command_master #(
   parameter  int p_ADDRESS_WIDTH = 2,
   parameter  int p_DATA_WIDTH    = 8,
   localparam int lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? p_DATA_WIDTH / 8 : 1
) (
   input  logic                       i_ACLK,
   input  logic                       i_ARESETN,

   input  logic                       i_CMD_VALID,
   output logic                       o_CMD_READY,
   input  logic                       i_CMD_WRITE,
   input  logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR,
   input  logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA,
   input  logic [lp_STROBE_WIDTH-1:0] i_CMD_WSTRB,

   output logic                       o_RSP_VALID,
   input  logic                       i_RSP_READY,
   output logic                       o_RSP_WRITE,
   output logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA,
   output logic [1:0]                 o_RSP_RESP,

   axi4_lite_command_master_if.master m_axi
);

   localparam logic [2:0] lp_STATE_IDLE   = 3'd0;
   localparam logic [2:0] lp_STATE_WRITE  = 3'd1;
   localparam logic [2:0] lp_STATE_WAIT_B = 3'd2;
   localparam logic [2:0] lp_STATE_READ   = 3'd3;
   localparam logic [2:0] lp_STATE_WAIT_R = 3'd4;
   localparam logic [2:0] lp_STATE_RESP   = 3'd5;

   logic [2:0] state;

   // Protection attributes are fixed: unprivileged, secure, data access.
   assign m_axi.awprot = 3'b000;
   assign m_axi.arprot = 3'b000;

   // Transaction FSM; every output is a register so the slave sees clean edges.
   always_ff @(posedge i_ACLK) begin
      if (!i_ARESETN) begin
         state         <= lp_STATE_IDLE;
         o_CMD_READY   <= 1'b0;
         o_RSP_VALID   <= 1'b0;
         o_RSP_WRITE   <= 1'b0;
         o_RSP_RDATA   <= '0;
         o_RSP_RESP    <= 2'b00;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wstrb   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
      end else begin
         case (state)
            lp_STATE_IDLE: begin
               if (i_CMD_VALID && o_CMD_READY) begin
                  o_CMD_READY <= 1'b0;
                  if (i_CMD_WRITE) begin
                     m_axi.awaddr  <= i_CMD_ADDR;
                     m_axi.wdata   <= i_CMD_WDATA;
                     m_axi.wstrb   <= i_CMD_WSTRB;
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     state         <= lp_STATE_WRITE;
                  end else begin
                     m_axi.araddr  <= i_CMD_ADDR;
                     m_axi.arvalid <= 1'b1;
                     state         <= lp_STATE_READ;
                  end
               end else begin
                  // Also covers the first edge after reset release.
                  o_CMD_READY <= 1'b1;
               end
            end

            lp_STATE_WRITE: begin
               // AW and W complete independently; each valid drops once and stays low.
               if (m_axi.awvalid && m_axi.awready) begin
                  m_axi.awvalid <= 1'b0;
               end
               if (m_axi.wvalid && m_axi.wready) begin
                  m_axi.wvalid <= 1'b0;
               end
               if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
                  m_axi.bready <= 1'b1;
                  state        <= lp_STATE_WAIT_B;
               end
            end

            lp_STATE_WAIT_B: begin
               if (m_axi.bvalid && m_axi.bready) begin
                  m_axi.bready <= 1'b0;
                  o_RSP_VALID  <= 1'b1;
                  o_RSP_WRITE  <= 1'b1;
                  o_RSP_RDATA  <= '0;
                  o_RSP_RESP   <= m_axi.bresp;
                  state        <= lp_STATE_RESP;
               end
            end

            lp_STATE_READ: begin
               if (m_axi.arready) begin
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
                  state         <= lp_STATE_WAIT_R;
               end
            end

            lp_STATE_WAIT_R: begin
               if (m_axi.rvalid && m_axi.rready) begin
                  m_axi.rready <= 1'b0;
                  o_RSP_VALID  <= 1'b1;
                  o_RSP_WRITE  <= 1'b0;
                  o_RSP_RDATA  <= m_axi.rdata;
                  o_RSP_RESP   <= m_axi.rresp;
                  state        <= lp_STATE_RESP;
               end
            end

            lp_STATE_RESP: begin
               if (i_RSP_READY) begin
                  o_RSP_VALID <= 1'b0;
                  o_CMD_READY <= 1'b1;
                  state       <= lp_STATE_IDLE;
               end
            end

            default: begin
               state <= lp_STATE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_command_master.sv
// tb/tb_axi4_lite_command_master.sv - scoreboard bench for the AXI4-Lite command master
module tb_axi4_lite_command_master;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [1:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic [0:0] cmd_wstrb;
   logic       rsp_valid, rsp_ready, rsp_write;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_resp;

   axi4_lite_command_master_if #(.p_ADDRESS_WIDTH(2), .p_DATA_WIDTH(8)) bus ();

   axi4_lite_command_master #(.p_ADDRESS_WIDTH(2), .p_DATA_WIDTH(8)) dut (
      .i_ACLK      (clk),
      .i_ARESETN   (rstn),
      .i_CMD_VALID (cmd_valid),
      .o_CMD_READY (cmd_ready),
      .i_CMD_WRITE (cmd_write),
      .i_CMD_ADDR  (cmd_addr),
      .i_CMD_WDATA (cmd_wdata),
      .i_CMD_WSTRB (cmd_wstrb),
      .o_RSP_VALID (rsp_valid),
      .i_RSP_READY (rsp_ready),
      .o_RSP_WRITE (rsp_write),
      .o_RSP_RDATA (rsp_rdata),
      .o_RSP_RESP  (rsp_resp),
      .m_axi       (bus)
   );

   initial forever #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // expected response: {write, rdata[7:0], resp[1:0]}
   logic [10:0] exp_q[$];

   // slave model knobs
   int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   bit         b_early = 1'b0, b_hold = 1'b0;
   logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [7:0] r_data_cfg = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic [0:0] s, input bit expect_rsp, input logic [10:0] e);
      int n = 0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_timeout", cmd_ready, 1);
      if (expect_rsp) exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rsp_timeout", rsp_valid, 1);
   endtask

   // Slave responder: drives ready/valid on the falling edge with programmable delays.
   initial begin : slave
      int aw_cnt, w_cnt, ar_cnt, r_cnt;
      bit aw_v_q, w_v_q, ar_v_q, b_r_q, r_r_q;
      bit aw_seen, w_seen, ar_seen;
      bit hs_aw, hs_w, hs_ar, hs_b, hs_r;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid  = 1'b0; bus.bresp  = 2'b00;
      bus.rvalid  = 1'b0; bus.rdata  = 8'h00; bus.rresp = 2'b00;
      forever begin
         @(negedge clk);
         hs_aw = aw_v_q && bus.awready;
         hs_w  = w_v_q && bus.wready;
         hs_ar = ar_v_q && bus.arready;
         hs_b  = bus.bvalid && b_r_q;
         hs_r  = bus.rvalid && r_r_q;
         if (!rstn) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
            bus.bvalid  = 1'b0; bus.rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0;
         end else begin
            if (hs_aw) aw_seen = 1'b1;
            if (hs_w)  w_seen  = 1'b1;
            if (!bus.awvalid) begin bus.awready = 1'b0; aw_cnt = 0; end
            else begin bus.awready = (aw_cnt >= aw_delay); aw_cnt++; end
            if (!bus.wvalid) begin bus.wready = 1'b0; w_cnt = 0; end
            else begin bus.wready = (w_cnt >= w_delay); w_cnt++; end
            if (!bus.arvalid) begin bus.arready = 1'b0; ar_cnt = 0; end
            else begin bus.arready = (ar_cnt >= ar_delay); ar_cnt++; end
            if (hs_b) begin
               bus.bvalid = 1'b0;
               aw_seen = 1'b0;
               w_seen  = 1'b0;
            end else begin
               bus.bvalid = !b_hold && (b_early || (aw_seen && w_seen));
            end
            bus.bresp = b_resp_cfg;
            if (hs_ar) begin ar_seen = 1'b1; r_cnt = 0; end
            if (hs_r) begin
               bus.rvalid = 1'b0;
               ar_seen = 1'b0;
            end else if (ar_seen) begin
               if (r_cnt >= r_delay) begin
                  bus.rvalid = 1'b1;
                  bus.rdata  = r_data_cfg;
                  bus.rresp  = r_resp_cfg;
               end
               r_cnt++;
            end
         end
         aw_v_q = bus.awvalid;
         w_v_q  = bus.wvalid;
         ar_v_q = bus.arvalid;
         b_r_q  = bus.bready;
         r_r_q  = bus.rready;
      end
   end

   // Response monitor: pops the scoreboard on every response handshake.
   initial begin : monitor
      logic [10:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rstn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("rsp_write", rsp_write, e[10]);
               check("rsp_rdata", rsp_rdata, e[9:2]);
               check("rsp_resp",  rsp_resp,  e[1:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic       w;
      logic [1:0] a, br, rr;
      logic [7:0] d, rd;

      rstn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0;
      cmd_wdata = 8'h00; cmd_wstrb = 1'b0; rsp_ready = 1'b0;

      // reset held three cycles with a command pending
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_cmd_ready", cmd_ready, 0);
         check("rst_awvalid", bus.awvalid, 0);
         check("rst_wvalid", bus.wvalid, 0);
         check("rst_arvalid", bus.arvalid, 0);
         check("rst_bready", bus.bready, 0);
         check("rst_rready", bus.rready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
      end
      rstn = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      check("rel_cmd_ready", cmd_ready, 1);

      // minimum-latency write
      rsp_ready = 1'b1;
      issue(1'b1, 2'd2, 8'hA5, 1'b1, 1'b1, {1'b1, 8'h00, 2'b00});
      check("w_awvalid", bus.awvalid, 1);
      check("w_wvalid", bus.wvalid, 1);
      check("w_awaddr", bus.awaddr, 2);
      check("w_wdata", bus.wdata, 8'hA5);
      check("w_wstrb", bus.wstrb, 1);
      check("w_cmd_ready", cmd_ready, 0);
      check("w_bready_early", bus.bready, 0);
      @(negedge clk);
      check("w_awvalid_drop", bus.awvalid, 0);
      check("w_wvalid_drop", bus.wvalid, 0);
      check("w_bready", bus.bready, 1);
      @(negedge clk);
      check("w_bready_drop", bus.bready, 0);
      check("w_rsp_valid_n3", rsp_valid, 1);
      @(negedge clk);
      check("w_rsp_done", rsp_valid, 0);
      check("w_cmd_ready_back", cmd_ready, 1);

      // AWREADY delayed 3 cycles, BVALID presented early, EXOKAY passthrough
      aw_delay = 3; b_early = 1'b1; b_resp_cfg = 2'b01;
      issue(1'b1, 2'd3, 8'h5A, 1'b1, 1'b1, {1'b1, 8'h00, 2'b01});
      for (int i = 0; i < 4; i++) begin
         check("d_awvalid_held", bus.awvalid, 1);
         check("d_awaddr_stable", bus.awaddr, 3);
         check("d_wvalid", bus.wvalid, (i == 0) ? 1 : 0);
         check("d_bready_low", bus.bready, 0);
         @(negedge clk);
      end
      check("d_awvalid_drop", bus.awvalid, 0);
      check("d_bready", bus.bready, 1);
      wait_rsp();
      b_early = 1'b0; aw_delay = 0;
      @(negedge clk);

      // read with a two-cycle R delay and SLVERR
      r_delay = 2; r_data_cfg = 8'h3C; r_resp_cfg = 2'b10; b_resp_cfg = 2'b00;
      issue(1'b0, 2'd1, 8'h00, 1'b0, 1'b1, {1'b0, 8'h3C, 2'b10});
      check("r_arvalid", bus.arvalid, 1);
      check("r_araddr", bus.araddr, 1);
      check("r_awvalid", bus.awvalid, 0);
      check("r_rready_early", bus.rready, 0);
      @(negedge clk);
      check("r_arvalid_drop", bus.arvalid, 0);
      check("r_rready", bus.rready, 1);
      wait_rsp();
      @(negedge clk);

      // response stalled five cycles with the next command already waiting
      r_delay = 0; r_data_cfg = 8'h81; r_resp_cfg = 2'b00; rsp_ready = 1'b0;
      issue(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, {1'b0, 8'h81, 2'b00});
      wait_rsp();
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'hC3; cmd_wstrb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("s_rsp_valid", rsp_valid, 1);
         check("s_rsp_rdata", rsp_rdata, 8'h81);
         check("s_rsp_resp", rsp_resp, 0);
         check("s_rsp_write", rsp_write, 0);
         check("s_cmd_ready", cmd_ready, 0);
         check("s_awvalid", bus.awvalid, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      exp_q.push_back({1'b1, 8'h00, 2'b00});
      @(negedge clk);
      check("s_rsp_done", rsp_valid, 0);
      check("s_cmd_ready_back", cmd_ready, 1);
      check("s_awvalid_not_yet", bus.awvalid, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_awvalid", bus.awvalid, 1);
      check("b2b_awaddr", bus.awaddr, 3);
      check("b2b_wdata", bus.wdata, 8'hC3);
      wait_rsp();
      @(negedge clk);

      // reset while waiting for B
      b_hold = 1'b1;
      issue(1'b1, 2'd1, 8'h77, 1'b1, 1'b0, 11'd0);
      @(negedge clk);
      check("x_bready_wait", bus.bready, 1);
      rstn = 1'b0;
      @(negedge clk);
      check("x_bready", bus.bready, 0);
      check("x_rsp_valid", rsp_valid, 0);
      check("x_cmd_ready", cmd_ready, 0);
      check("x_awvalid", bus.awvalid, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      b_hold = 1'b0;
      check("x_cmd_ready_back", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("x_no_rsp", rsp_valid, 0);
         check("x_bready_idle", bus.bready, 0);
      end

      // randomized mix of reads and writes with random slave delays
      for (int i = 0; i < 8; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = 2'($urandom_range(0, 3));
         d  = 8'($urandom_range(0, 255));
         rd = 8'($urandom_range(0, 255));
         br = 2'($urandom_range(0, 3));
         rr = 2'($urandom_range(0, 3));
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
         b_resp_cfg = br; r_resp_cfg = rr; r_data_cfg = rd;
         issue(w, a, d, 1'b1, 1'b1, w ? {1'b1, 8'h00, br} : {1'b0, rd, rr});
         if (w) check("m_awaddr", bus.awaddr, a);
         else   check("m_araddr", bus.araddr, a);
         wait_rsp();
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
